// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the multi-channel frequency meter.
// Duty measurement is enabled by defining FREQ_METER_DUTY_EN.
package freq_meter_pkg;

  typedef enum logic [1:0] {S_GATE, S_CLOSE, S_DIV, S_OUT} state_t;

  // Sub-steps of S_DIV: decide/issue, wait for frequency, wait for duty.
  typedef enum logic [1:0] {D_ISSUE, D_FREQ, D_DUTY} div_step_t;

  localparam int DUTY_SCALE = 1000;
  localparam int DUTY_W     = 10;

  // The dividend holds CLK_FS (up to 32 bits) times a CNT_W-bit count.
  function automatic int num_w(input int cnt_w);
    return cnt_w + 32;
  endfunction

endpackage

// File: rtl/freq_meter_mc_if.sv
// Result stream of freq_meter_mc (valid/ready).
// duty_pm exists only when FREQ_METER_DUTY_EN is defined.
interface freq_meter_mc_if #(
  parameter int OUT_W = 32,
  parameter int CH_W  = 2
);
  import freq_meter_pkg::*;

  logic [OUT_W-1:0]  freq_data;
  logic [CH_W-1:0]   freq_ch;
  logic              freq_err;
`ifdef FREQ_METER_DUTY_EN
  logic [DUTY_W-1:0] duty_pm;
`endif
  logic              freq_valid;
  logic              freq_ready;

  modport master (
    output freq_data, freq_ch, freq_err,
`ifdef FREQ_METER_DUTY_EN
    output duty_pm,
`endif
    output freq_valid,
    input  freq_ready
  );

  modport slave (
    input  freq_data, freq_ch, freq_err,
`ifdef FREQ_METER_DUTY_EN
    input  duty_pm,
`endif
    input  freq_valid,
    output freq_ready
  );

endinterface

// File: rtl/freq_div_seq.sv
// Unsigned restoring divider, one quotient bit per clock.
// A zero divisor yields an all-ones quotient; start while busy is ignored.
module freq_div_seq #(
  parameter int DW = 64,
  parameter int VW = 32
) (
  input  logic          clk_fs,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int CW = $clog2(DW + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [DW-1:0] quo;
  logic [VW-1:0] rem;
  logic [VW-1:0] dvs;
  logic [VW:0]   trial;
  logic [VW:0]   diff;

  assign trial = {rem, quo[DW-1]};
  assign diff  = trial - {1'b0, dvs};

  // Load, DW shift/subtract steps, then one cycle to publish the quotient.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          cnt  <= CW'(DW);
          quo  <= dividend;
          rem  <= '0;
          dvs  <= divisor;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        if (trial >= {1'b0, dvs}) begin
          rem <= diff[VW-1:0];
          quo <= {quo[DW-2:0], 1'b1};
        end else begin
          rem <= trial[VW-1:0];
          quo <= {quo[DW-2:0], 1'b0};
        end
      end else begin
        busy     <= 1'b0;
        done     <= 1'b1;
        quotient <= quo;
      end
    end
  end

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel equal-precision frequency meter with one shared divider.
// Define FREQ_METER_DUTY_EN to add per-channel duty measurement (duty_pm).
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int CLK_FS   = 50_000_000,
  parameter int CH_NUM   = 4,
  parameter int GATE_CYC = 25_000_000,
  parameter int TMO_CYC  = 50_000_000,
  parameter int CNT_W    = 32,
  parameter int OUT_W    = 32
) (
  input  logic              clk_fs,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] sig_in,
  freq_meter_mc_if.master   res
);

  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int NUM_W = num_w(CNT_W);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_W-1:0] OUT_MAX  = NUM_W'({OUT_W{1'b1}});
  localparam logic [31:0]      CLK_FS_W = 32'(CLK_FS);
  localparam logic [31:0]      GATE_END = 32'(GATE_CYC - 1);
  localparam logic [31:0]      TMO_END  = 32'(TMO_CYC - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CH_NUM - 1);

  logic [CH_NUM-1:0] sync1, sync2, sync3, rise;
  logic [CH_NUM-1:0] opened, open_g, err;
  logic [CNT_W-1:0]  fx_cnt [CH_NUM];
  logic [CNT_W-1:0]  fs_cnt [CH_NUM];
  state_t            state;
  div_step_t         div_step;
  logic [31:0]       tmr;
  logic [CH_W-1:0]   ch_idx;
  logic              div_start, div_done;
  logic [NUM_W-1:0]  div_num, div_q, freq_num;
  logic [CNT_W-1:0]  div_den;
`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0]  hi_cnt [CH_NUM];
  logic [NUM_W-1:0]  duty_num;
  logic [OUT_W-1:0]  freq_hold;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic at_max(input logic [CNT_W-1:0] v);
    return v >= CNT_MAX - CNT_ONE;
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(input logic [NUM_W-1:0] q);
    return (q > OUT_MAX) ? {OUT_W{1'b1}} : q[OUT_W-1:0];
  endfunction

  assign rise     = sync2 & ~sync3;
  assign freq_num = {{CNT_W{1'b0}}, CLK_FS_W} * {32'd0, fx_cnt[ch_idx]};
  assign div_den  = fs_cnt[ch_idx];
`ifdef FREQ_METER_DUTY_EN
  assign duty_num = {32'd0, hi_cnt[ch_idx]} * {{CNT_W{1'b0}}, 32'(DUTY_SCALE)};
  assign div_num  = (div_step == D_DUTY) ? duty_num : freq_num;
`else
  assign div_num  = freq_num;
`endif

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  freq_div_seq #(.DW(NUM_W), .VW(CNT_W)) u_div (
    .clk_fs   (clk_fs),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_num),
    .divisor  (div_den),
    .done     (div_done),
    .quotient (div_q)
  );

  // Per-channel gating runs first; the state case below may override it on exit.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_GATE;
      div_step  <= D_ISSUE;
      tmr       <= '0;
      ch_idx    <= '0;
      div_start <= 1'b0;
      opened    <= '0;
      open_g    <= '0;
      err       <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        fx_cnt[i] <= '0;
        fs_cnt[i] <= '0;
`ifdef FREQ_METER_DUTY_EN
        hi_cnt[i] <= '0;
`endif
      end
      res.freq_data  <= '0;
      res.freq_ch    <= '0;
      res.freq_err   <= 1'b0;
      res.freq_valid <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
      res.duty_pm    <= '0;
      freq_hold      <= '0;
`endif
    end else begin
      div_start <= 1'b0;
      if (state == S_GATE || state == S_CLOSE) begin
        for (int i = 0; i < CH_NUM; i++) begin
          if (open_g[i]) begin
            fs_cnt[i] <= sat_inc(fs_cnt[i]);
            if (at_max(fs_cnt[i])) err[i] <= 1'b1;
`ifdef FREQ_METER_DUTY_EN
            if (sync2[i]) begin
              hi_cnt[i] <= sat_inc(hi_cnt[i]);
              if (at_max(hi_cnt[i])) err[i] <= 1'b1;
            end
`endif
            if (rise[i]) begin
              fx_cnt[i] <= sat_inc(fx_cnt[i]);
              if (at_max(fx_cnt[i])) err[i] <= 1'b1;
              if (state == S_CLOSE) open_g[i] <= 1'b0;
            end
          end else if (state == S_GATE && !opened[i] && rise[i]) begin
            opened[i] <= 1'b1;
            open_g[i] <= 1'b1;
          end
        end
      end

      case (state)
        S_GATE: begin
          tmr <= tmr + 32'd1;
          if (tmr == GATE_END) begin
            tmr   <= '0;
            state <= S_CLOSE;
          end
        end
        S_CLOSE: begin
          tmr <= tmr + 32'd1;
          if (open_g == '0 || tmr == TMO_END) begin
            err      <= err | open_g | ~opened;
            open_g   <= '0;
            tmr      <= '0;
            ch_idx   <= '0;
            div_step <= D_ISSUE;
            state    <= S_DIV;
          end
        end
        S_DIV: begin
          case (div_step)
            D_ISSUE: begin
              if (err[ch_idx] || fs_cnt[ch_idx] == '0) begin
                res.freq_data  <= '0;
                res.freq_ch    <= ch_idx;
                res.freq_err   <= 1'b1;
                res.freq_valid <= 1'b1;
`ifdef FREQ_METER_DUTY_EN
                res.duty_pm    <= '0;
`endif
                state          <= S_OUT;
              end else begin
                div_start <= 1'b1;
                div_step  <= D_FREQ;
              end
            end
            D_FREQ: begin
              if (div_done) begin
`ifdef FREQ_METER_DUTY_EN
                freq_hold <= sat_out(div_q);
                div_start <= 1'b1;
                div_step  <= D_DUTY;
`else
                res.freq_data  <= sat_out(div_q);
                res.freq_ch    <= ch_idx;
                res.freq_err   <= 1'b0;
                res.freq_valid <= 1'b1;
                state          <= S_OUT;
`endif
              end
            end
`ifdef FREQ_METER_DUTY_EN
            D_DUTY: begin
              if (div_done) begin
                res.freq_data  <= freq_hold;
                res.duty_pm    <= (div_q > NUM_W'(DUTY_SCALE)) ? DUTY_W'(DUTY_SCALE)
                                                               : div_q[DUTY_W-1:0];
                res.freq_ch    <= ch_idx;
                res.freq_err   <= 1'b0;
                res.freq_valid <= 1'b1;
                state          <= S_OUT;
              end
            end
`endif
            default: div_step <= D_ISSUE;
          endcase
        end
        S_OUT: begin
          if (res.freq_ready) begin
            res.freq_valid <= 1'b0;
            if (ch_idx == LAST_CH) begin
              state  <= S_GATE;
              tmr    <= '0;
              opened <= '0;
              err    <= '0;
              for (int i = 0; i < CH_NUM; i++) begin
                fx_cnt[i] <= '0;
                fs_cnt[i] <= '0;
`ifdef FREQ_METER_DUTY_EN
                hi_cnt[i] <= '0;
`endif
              end
            end else begin
              ch_idx   <= ch_idx + CH_W'(1);
              div_step <= D_ISSUE;
              state    <= S_DIV;
            end
          end
        end
        default: state <= S_GATE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_mc.sv
// Bench for freq_meter_mc: directed table rows plus randomized rounds checked
// against an arithmetic model (f = CLK_FS/period, duty = 1000*high/period).
module tb_freq_meter_mc;
  import freq_meter_pkg::*;

  localparam int CLK_FS   = 50_000_000;
  localparam int CH_NUM   = 4;
  localparam int GATE_CYC = 2000;
  localparam int TMO_CYC  = 4000;
  localparam int CNT_W    = 32;
  localparam int OUT_W    = 32;
  localparam int CH_W     = 2;
  localparam int NROUNDS  = 4;

  localparam logic [1:0] M_PER  = 2'd0;
  localparam logic [1:0] M_LOW  = 2'd1;
  localparam logic [1:0] M_ONCE = 2'd2;

  typedef struct packed {
    logic [1:0]  mode;
    logic [7:0]  per;
    logic [7:0]  hi;
    logic [31:0] exp_freq;
    logic        exp_err;
    logic [9:0]  exp_duty;
  } ch_vec_t;

  logic              clk_fs = 1'b0;
  logic              rst_n  = 1'b1;
  logic [CH_NUM-1:0] sig_in;

  ch_vec_t vecs [NROUNDS][CH_NUM];
  ch_vec_t cur  [CH_NUM];
  int      ofs  [CH_NUM];
  int      cyc;
  int      tests = 0;
  int      fails = 0;

  freq_meter_mc_if #(.OUT_W(OUT_W), .CH_W(CH_W)) bus ();

  freq_meter_mc #(
    .CLK_FS(CLK_FS), .CH_NUM(CH_NUM), .GATE_CYC(GATE_CYC),
    .TMO_CYC(TMO_CYC), .CNT_W(CNT_W), .OUT_W(OUT_W)
  ) dut (
    .clk_fs (clk_fs),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .res    (bus.master)
  );

  always #5 clk_fs = ~clk_fs;

  function automatic ch_vec_t mk(input logic [1:0] mode, input int per, input int hi,
                                 input int f, input bit e, input int d);
    ch_vec_t v;
    v.mode = mode;       v.per = 8'(per);     v.hi = 8'(hi);
    v.exp_freq = 32'(f); v.exp_err = e;       v.exp_duty = 10'(d);
    return v;
  endfunction

  // Reference model: a periodic input measured over whole periods gives exact ratios.
  function automatic ch_vec_t model_ch(input logic [1:0] mode, input int per, input int hi);
    if (mode == M_PER)
      return mk(mode, per, hi, CLK_FS / per, 1'b0, (DUTY_SCALE * hi) / per);
    return mk(mode, per, hi, 0, 1'b1, 0);
  endfunction

  function automatic logic gen_level(input ch_vec_t v, input int t);
    if (t < 0) return 1'b0;
    case (v.mode)
      M_PER:   return (t % int'(v.per)) >= (int'(v.per) - int'(v.hi));
      M_ONCE:  return t < 3;
      default: return 1'b0;
    endcase
  endfunction

  // Input generators start low at reset release so no false edge is seen.
  initial begin
    sig_in = '0;
    cyc    = 0;
    forever begin
      @(negedge clk_fs);
      if (!rst_n) begin
        cyc    = 0;
        sig_in = '0;
      end else begin
        for (int i = 0; i < CH_NUM; i++) sig_in[i] = gen_level(cur[i], cyc - ofs[i]);
        cyc++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int r);
    @(negedge clk_fs);
    rst_n = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      cur[i] = vecs[r][i];
      ofs[i] = (vecs[r][i].mode == M_ONCE) ? 500 : int'($urandom_range(0, 99));
    end
    repeat (3) @(negedge clk_fs);
    rst_n = 1'b1;
  endtask

  task automatic runRound(input int r, input bit bp, input bit abort);
    int               waitc;
    bit               long_close;
    bit               stable;
    logic [OUT_W-1:0] hold_d;
    logic [CH_W-1:0]  hold_c;
    string            tag;
    applyStimulus(r);
    bus.freq_ready = !bp;
    long_close = 1'b0;
    for (int i = 0; i < CH_NUM; i++) if (vecs[r][i].mode == M_ONCE) long_close = 1'b1;
    for (int k = 0; k < CH_NUM; k++) begin
      tag   = $sformatf("r%0d ch%0d", r, k);
      waitc = 0;
      while (bus.freq_valid !== 1'b1 && waitc < 10000) begin
        @(negedge clk_fs);
        waitc++;
      end
      if (bus.freq_valid !== 1'b1) begin
        checkOutput({tag, " valid wait"}, 64'(bus.freq_valid), 64'd1);
        return;
      end
      if (k == 0)
        checkOutput({tag, " close time"},
                    64'(long_close ? (waitc >= 6000 && waitc <= 6300) : (waitc < 2400)), 64'd1);
      if (bp && k == 0) begin
        hold_d = bus.freq_data;
        hold_c = bus.freq_ch;
        stable = 1'b1;
        repeat (100) begin
          @(negedge clk_fs);
          if (bus.freq_valid !== 1'b1 || bus.freq_data !== hold_d || bus.freq_ch !== hold_c)
            stable = 1'b0;
        end
        checkOutput({tag, " backpressure hold"}, 64'(stable), 64'd1);
        bus.freq_ready = 1'b1;
      end
      checkOutput({tag, " freq_ch"},   64'(bus.freq_ch),   64'(k));
      checkOutput({tag, " freq_data"}, 64'(bus.freq_data), 64'(vecs[r][k].exp_freq));
      checkOutput({tag, " freq_err"},  64'(bus.freq_err),  64'(vecs[r][k].exp_err));
`ifdef FREQ_METER_DUTY_EN
      checkOutput({tag, " duty_pm"},   64'(bus.duty_pm),   64'(vecs[r][k].exp_duty));
`endif
      @(posedge clk_fs);
      @(negedge clk_fs);
      if (abort && k == 0) begin
        repeat (10) @(negedge clk_fs);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, " rst freq_valid"}, 64'(bus.freq_valid), 64'd0);
        checkOutput({tag, " rst freq_data"},  64'(bus.freq_data),  64'd0);
        checkOutput({tag, " rst freq_ch"},    64'(bus.freq_ch),    64'd0);
        checkOutput({tag, " rst freq_err"},   64'(bus.freq_err),   64'd0);
        return;
      end
    end
  endtask

  initial begin
    int per;
    bus.freq_ready = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      cur[i] = mk(M_LOW, 1, 0, 0, 1'b1, 0);
      ofs[i] = 0;
    end

    vecs[0][0] = mk(M_PER,  10,  3,  5_000_000, 1'b0, 300);
    vecs[0][1] = mk(M_PER,   7,  3,  7_142_857, 1'b0, 428);
    vecs[0][2] = mk(M_LOW,   1,  0,          0, 1'b1,   0);
    vecs[0][3] = mk(M_PER,  20, 10,  2_500_000, 1'b0, 500);
    vecs[1][0] = mk(M_PER,  10,  5,  5_000_000, 1'b0, 500);
    vecs[1][1] = mk(M_PER,  13,  4,  3_846_153, 1'b0, 307);
    vecs[1][2] = mk(M_PER,   4,  2, 12_500_000, 1'b0, 500);
    vecs[1][3] = mk(M_ONCE,  1,  0,          0, 1'b1,   0);
    for (int r = 2; r < NROUNDS; r++) begin
      for (int i = 0; i < CH_NUM; i++) begin
        per = int'($urandom_range(3, 60));
        if (i != 0 && $urandom_range(0, 4) == 0)
          vecs[r][i] = model_ch(M_LOW, 1, 0);
        else
          vecs[r][i] = model_ch(M_PER, per, int'($urandom_range(1, per - 1)));
      end
    end

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk_fs);
    checkOutput("reset freq_valid", 64'(bus.freq_valid), 64'd0);
    checkOutput("reset freq_data",  64'(bus.freq_data),  64'd0);
    checkOutput("reset freq_ch",    64'(bus.freq_ch),    64'd0);
    checkOutput("reset freq_err",   64'(bus.freq_err),   64'd0);
`ifdef FREQ_METER_DUTY_EN
    checkOutput("reset duty_pm",    64'(bus.duty_pm),    64'd0);
`endif

    runRound(0, 1'b1, 1'b0);
    runRound(1, 1'b0, 1'b0);
    runRound(2, 1'b0, 1'b1);
    runRound(2, 1'b0, 1'b0);
    runRound(3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/freq_meter_mc.md
# freq_meter_mc

Multi-channel, single-clock, equal-precision frequency meter for the DSO trigger/measurement path. `freq_meter_mc` samples `CH_NUM` asynchronous input signals on the system clock and measures every channel over one shared gate. Each channel's gate is aligned to that channel's own rising edges. Results come from one shared sequential divider and are delivered channel by channel over a valid/ready stream.

## Interface
- `CLK_FS`, 50_000_000: system clock frequency in Hz.
- `CH_NUM`, 4: number of measured channels, 1..16.
- `GATE_CYC`, 25_000_000: soft gate length in `clk_fs` cycles.
- `TMO_CYC`, 50_000_000: after the soft gate ends, maximum number of cycles to wait for channels to close.
- `CNT_W`, 32: width of the edge, reference and high-time counters.
- `OUT_W`, 32: result width.
- `clk_fs` in 1: system/reference clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sig_in` in `CH_NUM`: measured signals. Asynchronous; synchronised internally.
- `freq_data` out `OUT_W`: frequency in Hz.
- `freq_ch` out `$clog2(CH_NUM)` (min 1): channel index of the current result.
- `freq_err` out 1: channel had no edge in the gate, or timed out.
- `duty_pm` out 10: duty cycle in per-mille. Present only with the macro (see Configuration).
- `freq_valid` out 1: result valid.
- `freq_ready` in 1: consumer accepts the result.

## Operation
- **Per channel:** 2-FF synchroniser, then a third register for rising-edge detect. Measurable input is < `CLK_FS`/2.
- **Top FSM:** `S_GATE` → `S_CLOSE` → `S_DIV` → `S_OUT` → (next channel: `S_DIV` | last channel: `S_GATE`).
- **`S_GATE`:** soft-gate counter runs `GATE_CYC` cycles.
  - A channel's real gate opens on its first sync rising edge while the soft gate is high.
  - While the real gate is open: `fx_cnt` counts rising edges, `fs_cnt` counts clocks, `hi_cnt` counts clocks with the sync level high.
  - The edge that opens the gate is not counted.
- **`S_CLOSE`:** each open real gate closes on its next rising edge; that closing edge is counted in `fx_cnt`.
  - The FSM leaves `S_CLOSE` when all channels are closed or never opened, or when `TMO_CYC` cycles have elapsed.
  - A channel still open at timeout is flagged `err`.
  - A channel that never opened is flagged `err`.
- **`S_DIV`:** compute `(CLK_FS * fx_cnt) / fs_cnt` with the shared divider.
  - Numerator width is `CNT_W+32`.
  - Quotient is truncated. If it exceeds `OUT_W` bits, it saturates to all-ones.
  - An `err` channel, or `fs_cnt == 0`, skips the divider and reports 0.
- **`S_OUT`:** assert `freq_valid`.
  - `freq_data`, `freq_ch`, `freq_err` and `duty_pm` are held stable while valid is high and ready is low.
  - Transfer happens on a cycle where `freq_valid` and `freq_ready` are both high.
  - Channels are delivered in ascending order, 0..`CH_NUM`-1.
- **Restart:** per-channel counters clear on entry to `S_GATE`. Inputs are ignored outside `S_GATE`/`S_CLOSE`. There is no measurement overlap.
- **Counter saturation:** any counter reaching all-ones saturates and sets `err` for that channel.

## Timing
- **Reset values:** `freq_data`=0, `freq_ch`=0, `freq_err`=0, `duty_pm`=0, `freq_valid`=0. FSM in `S_GATE`, all counters 0.
- **Reset mid-operation:** any in-flight division or held result is discarded. Measurement restarts from a fresh `S_GATE` after reset release.
- **Input latency:** 3 cycles from `sig_in` to the edge pulse.
- **Divider:** restoring, 1 quotient bit per cycle. Latency is `CNT_W+32`+2 cycles from start to done.
- **Valid timing:** `freq_valid` rises the cycle after the divider reports done.
- **Back-to-back:** with `freq_ready` held high, the next channel's `S_DIV` starts the cycle after the handshake.
- **Round time:** at least `GATE_CYC` + close time + `CH_NUM`·(`CNT_W`+35) cycles.

## Configuration
- **Macro:** `FREQ_METER_DUTY_EN`.
- **Defined:** after the frequency division, the same divider computes `hi_cnt*1000/fs_cnt` and drives `duty_pm`, clamped to 1000. This adds `CNT_W+32`+2 cycles per channel. Error channels report 0.
- **Undefined:** no `duty_pm` port, no `hi_cnt` counters, no second division.

## Structure
- **Package `freq_meter_pkg`:** FSM state enum; `NUM_W = CNT_W+32` derivation; `DUTY_SCALE = 1000`.
- **Sub-module `freq_div_seq`:** unsigned restoring divider.
  - Ports: `clk_fs`, `rst_n`, start, dividend, divisor, done, quotient.
  - Asserting start while busy is ignored.
  - Divisor 0 returns all-ones; the top never issues divisor 0.

## Test plan
Common setup: `CLK_FS`=50_000_000, `GATE_CYC`=2000, `TMO_CYC`=4000, `CH_NUM`=4, `CNT_W`=32.
- **Exact frequencies:** ch0 period 10 clk → `freq_data`=5_000_000, `err`=0. ch1 period 7 clk → 7_142_857.
- **No signal:** ch2 held 0 → `freq_data`=0, `freq_err`=1. The other channels are unaffected.
- **Timeout:** ch3 gives one edge inside the soft gate, then stops → `freq_err`=1, result 0, exit after 4000 cycles of `S_CLOSE`.
- **Backpressure:** `freq_ready` low for 100 cycles → `freq_valid` stays high and `freq_data`/`freq_ch` are unchanged. Order 0,1,2,3 is preserved.
- **Reset mid-division:** assert `rst_n` low during `S_DIV` → all outputs 0 immediately. The next round reports correct values.
- **Duty:** with `FREQ_METER_DUTY_EN`, ch0 3 clk high / 7 clk low → `duty_pm`=300, `freq_data`=5_000_000.
